// File: rtl/traffic_light_ctrl_param_if.sv
// Sensor and lamp bundle of the two-street intersection controller.
// The controller sits on the slave side and the street environment on the master side.
interface traffic_light_ctrl_param_if;
  logic       sa;
  logic       sb;
  logic       night;
  logic       Ra;
  logic       Ya;
  logic       Ga;
  logic       Rb;
  logic       Yb;
  logic       Gb;
  logic [2:0] phase;

  modport master (
    output sa, sb, night,
    input  Ra, Ya, Ga, Rb, Yb, Gb, phase
  );

  modport slave (
    input  sa, sb, night,
    output Ra, Ya, Ga, Rb, Yb, Gb, phase
  );
endinterface

// File: rtl/traffic_light_ctrl_param.sv
// Sensor-actuated two-street traffic light controller with a 1 s prescaler, min/max green with
// gap-out, all-red clearance and a flashing-yellow night mode. Street A is the rest street.
module traffic_light_ctrl_param #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int MIN_GREEN = 10,
  parameter int MAX_GREEN = 60,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 2
) (
  input logic                         clk,
  input logic                         resetn,
  traffic_light_ctrl_param_if.slave   bus
);

  typedef enum logic [2:0] {
    A_GRN  = 3'd0,
    A_YEL  = 3'd1,
    RED_AB = 3'd2,
    B_GRN  = 3'd3,
    B_YEL  = 3'd4,
    RED_BA = 3'd5,
    FLASH  = 3'd6
  } state_e;

  localparam int              CW      = $clog2(TICK_DIV);
  localparam logic [CW-1:0]   PRE_MAX = CW'(TICK_DIV - 1);
  localparam logic [8:0]      MIN_G   = 9'(MIN_GREEN);
  localparam logic [8:0]      MAX_G   = 9'(MAX_GREEN);
  localparam logic [8:0]      YEL     = 9'(YELLOW);
  localparam logic [8:0]      AR      = 9'(ALL_RED);

  // Lamp vector order: {Ra, Ya, Ga, Rb, Yb, Gb}
  localparam logic [5:0] L_A_GRN = 6'b001_100;
  localparam logic [5:0] L_A_YEL = 6'b010_100;
  localparam logic [5:0] L_RED   = 6'b100_100;
  localparam logic [5:0] L_B_GRN = 6'b100_001;
  localparam logic [5:0] L_B_YEL = 6'b100_010;

  logic [1:0]    sa_sync_q, sb_sync_q, night_sync_q;
  logic          sa_s, sb_s, night_s;
  logic [CW-1:0] pre_q, pre_d;
  logic [7:0]    sec_q, sec_d;
  state_e        state_q, state_d;
  logic          blink_q, blink_d;
  logic [5:0]    lamps_q, lamps_d;
  logic          tick;
  logic [8:0]    s;

  assign sa_s    = sa_sync_q[1];
  assign sb_s    = sb_sync_q[1];
  assign night_s = night_sync_q[1];

  assign tick = (pre_q == PRE_MAX);
  // Completed ticks including the one ending now; 9 bits so a saturated sec still compares correctly.
  assign s    = {1'b0, sec_q} + 9'd1;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d = state_q;
    blink_d = blink_q;
    pre_d   = pre_q;
    sec_d   = sec_q;
    lamps_d = L_RED;

    case (state_q)
      A_GRN: begin
        if (tick && s >= MIN_G && (night_s || (sb_s && !sa_s) || (sb_s && s >= MAX_G)))
          state_d = A_YEL;
      end
      A_YEL: begin
        if (tick && s >= YEL) state_d = RED_AB;
      end
      RED_AB: begin
        if (tick && s >= AR) state_d = night_s ? FLASH : B_GRN;
      end
      B_GRN: begin
        if (tick && s >= MIN_G && (night_s || !sb_s || s >= MAX_G))
          state_d = B_YEL;
      end
      B_YEL: begin
        if (tick && s >= YEL) state_d = RED_BA;
      end
      RED_BA: begin
        if (tick && s >= AR) state_d = night_s ? FLASH : A_GRN;
      end
      FLASH: begin
        if (tick) begin
          if (!night_s) state_d = RED_BA;
          else          blink_d = !blink_q;
        end
      end
      default: state_d = RED_BA;
    endcase

    // Every phase starts from a fresh prescaler so D ticks last exactly D*TICK_DIV cycles.
    if (state_d != state_q) begin
      pre_d = '0;
      sec_d = '0;
      if (state_d == FLASH) blink_d = 1'b1;
    end else begin
      pre_d = tick ? '0 : pre_q + CW'(1);
      if (tick && sec_q != 8'hFF) sec_d = sec_q + 8'd1;
    end

    case (state_d)
      A_GRN:   lamps_d = L_A_GRN;
      A_YEL:   lamps_d = L_A_YEL;
      B_GRN:   lamps_d = L_B_GRN;
      B_YEL:   lamps_d = L_B_YEL;
      FLASH:   lamps_d = {1'b0, blink_d, 1'b0, 1'b0, blink_d, 1'b0};
      default: lamps_d = L_RED;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sa_sync_q    <= '0;
      sb_sync_q    <= '0;
      night_sync_q <= '0;
      pre_q        <= '0;
      sec_q        <= '0;
      state_q      <= RED_BA;
      blink_q      <= 1'b0;
      lamps_q      <= L_RED;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      sa_sync_q    <= {sa_sync_q[0], bus.sa};
      sb_sync_q    <= {sb_sync_q[0], bus.sb};
      night_sync_q <= {night_sync_q[0], bus.night};
      pre_q        <= pre_d;
      sec_q        <= sec_d;
      state_q      <= state_d;
      blink_q      <= blink_d;
      lamps_q      <= lamps_d;
    end
  end

  assign bus.Ra    = lamps_q[5];
  assign bus.Ya    = lamps_q[4];
  assign bus.Ga    = lamps_q[3];
  assign bus.Rb    = lamps_q[2];
  assign bus.Yb    = lamps_q[1];
  assign bus.Gb    = lamps_q[0];
  assign bus.phase = state_q;

  a_no_dual_green: assert property (@(posedge clk) disable iff (!resetn) !(lamps_q[3] && lamps_q[0]));

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Scoreboard bench: expected phase segments are queued with the stimulus and checked
// against each phase the controller actually produces.
module tb_traffic_light_ctrl_param;
  localparam int TICK_DIV  = 4;
  localparam int MIN_GREEN = 3;
  localparam int MAX_GREEN = 6;
  localparam int YELLOW    = 2;
  localparam int ALL_RED   = 1;

  localparam logic [2:0] P_AG = 3'd0, P_AY = 3'd1, P_RAB = 3'd2, P_BG = 3'd3;
  localparam logic [2:0] P_BY = 3'd4, P_RBA = 3'd5, P_FL = 3'd6;

  // {Ra, Ya, Ga, Rb, Yb, Gb}
  localparam logic [5:0] L_AG = 6'b001100, L_AY = 6'b010100, L_RED = 6'b100100;
  localparam logic [5:0] L_BG = 6'b100001, L_BY = 6'b100010, L_FLON = 6'b010010;

  localparam int ACT_NONE = 0, ACT_DROP_SB = 1, ACT_NIGHT_ON = 2, ACT_NIGHT_OFF = 3;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  traffic_light_ctrl_param_if bus ();

  traffic_light_ctrl_param #(
    .TICK_DIV (TICK_DIV),
    .MIN_GREEN(MIN_GREEN),
    .MAX_GREEN(MAX_GREEN),
    .YELLOW   (YELLOW),
    .ALL_RED  (ALL_RED)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0] phase;
    int         cycles;
  } seg_t;

  seg_t exp_q[$];
  int   n_checks   = 0;
  int   n_errors   = 0;
  int   dual_green = 0;
  int   seg_idx    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] lamps_now();
    return {bus.Ra, bus.Ya, bus.Ga, bus.Rb, bus.Yb, bus.Gb};
  endfunction

  // Lamps required on the k-th cycle (1-based) of a phase.
  function automatic logic [5:0] exp_lamps(input logic [2:0] ph, input int k);
    case (ph)
      P_AG:    return L_AG;
      P_AY:    return L_AY;
      P_BG:    return L_BG;
      P_BY:    return L_BY;
      P_FL:    return ((((k - 1) / TICK_DIV) % 2) == 0) ? L_FLON : 6'b000000;
      default: return L_RED;
    endcase
  endfunction

  task automatic push(input logic [2:0] ph, input int cyc);
    seg_t e;
    e.phase  = ph;
    e.cycles = cyc;
    exp_q.push_back(e);
  endtask

  // Called on the first negedge of a phase; returns on the first negedge of the next one
  // (or after budget cycles). An optional stimulus action fires on cycle act_at.
  task automatic observe(input int budget, input int act_at, input int act);
    seg_t       e;
    logic [2:0] cur;
    int         count = 0;
    int         lerr  = 0;
    seg_idx++;
    if (exp_q.size() == 0) begin
      check($sformatf("seg%0d_scoreboard_empty", seg_idx), 1, 0);
      return;
    end
    e   = exp_q.pop_front();
    cur = bus.phase;
    do begin
      count++;
      if (lamps_now() !== exp_lamps(e.phase, count)) lerr++;
      if (bus.Ga && bus.Gb) dual_green++;
      if (count == act_at) begin
        case (act)
          ACT_DROP_SB:   bus.sb    = 1'b0;
          ACT_NIGHT_ON:  bus.night = 1'b1;
          ACT_NIGHT_OFF: bus.night = 1'b0;
          default:       ;
        endcase
      end
      @(negedge clk);
    end while (bus.phase == cur && count < budget);
    check($sformatf("seg%0d_phase", seg_idx), 32'(cur), 32'(e.phase));
    check($sformatf("seg%0d_len_phase%0d", seg_idx, e.phase), count, e.cycles);
    check($sformatf("seg%0d_lamp_errs", seg_idx), lerr, 0);
  endtask

  task automatic apply_reset(input logic sa_v, input logic sb_v);
    resetn    = 1'b0;
    bus.sa    = sa_v;
    bus.sb    = sb_v;
    bus.night = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    resetn    = 1'b0;
    bus.sa    = 1'b0;
    bus.sb    = 1'b0;
    bus.night = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_phase", 32'(bus.phase), 32'(P_RBA));
    check("reset_lamps", 32'(lamps_now()), 32'(L_RED));

    // Reset release then no demand: A_GRN holds.
    resetn = 1'b1;
    push(P_RBA, 4); push(P_AG, 200);
    observe(100, 0, ACT_NONE);
    observe(200, 0, ACT_NONE);

    // B demand only: min green on A, max-out on B.
    apply_reset(1'b0, 1'b1);
    push(P_RBA, 4); push(P_AG, 12); push(P_AY, 8); push(P_RAB, 4);
    push(P_BG, 24); push(P_BY, 8); push(P_RBA, 4); push(P_AG, 12);
    repeat (8) observe(100, 0, ACT_NONE);

    // Conflicting demand: both greens max out.
    dual_green = 0;
    apply_reset(1'b1, 1'b1);
    push(P_RBA, 4); push(P_AG, 24); push(P_AY, 8); push(P_RAB, 4);
    push(P_BG, 24); push(P_BY, 8); push(P_RBA, 4); push(P_AG, 24);
    repeat (8) observe(100, 0, ACT_NONE);
    check("conflict_no_dual_green", dual_green, 0);

    // B gap-out: sb drops after the first B_GRN tick.
    apply_reset(1'b0, 1'b1);
    push(P_RBA, 4); push(P_AG, 12); push(P_AY, 8); push(P_RAB, 4);
    push(P_BG, 12); push(P_BY, 8); push(P_RBA, 4);
    repeat (4) observe(100, 0, ACT_NONE);
    observe(100, 5, ACT_DROP_SB);
    repeat (2) observe(100, 0, ACT_NONE);

    // Night mode via yellow and all-red, flash, then return to A_GRN.
    push(P_AG, 12); push(P_AY, 8); push(P_RAB, 4); push(P_FL, 16); push(P_RBA, 4);
    push(P_AG, 12); push(P_AY, 8); push(P_RAB, 4); push(P_FL, 6);
    observe(100, 2, ACT_NIGHT_ON);
    repeat (2) observe(100, 0, ACT_NONE);
    observe(100, 13, ACT_NIGHT_OFF);
    observe(100, 0, ACT_NONE);
    observe(100, 2, ACT_NIGHT_ON);
    repeat (2) observe(100, 0, ACT_NONE);
    observe(6, 0, ACT_NONE);

    // Reset mid-flash forces all-red immediately.
    resetn = 1'b0;
    #1;
    check("midflash_reset_phase", 32'(bus.phase), 32'(P_RBA));
    check("midflash_reset_lamps", 32'(lamps_now()), 32'(L_RED));
    bus.night = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    push(P_RBA, 4); push(P_AG, 20);
    observe(100, 0, ACT_NONE);
    observe(20, 0, ACT_NONE);
    check("final_no_dual_green", dual_green, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
